// File: rtl/pid_pkg.sv
// Shared types and helpers for the gen-2 balance PID controller.
package pid_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2
  } ss_state_t;

  // Clip a signed value into the range of a signed field of the given width.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                     input int width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    if (value > max_v) begin
      sat_signed = max_v;
    end else if (value < min_v) begin
      sat_signed = min_v;
    end else begin
      sat_signed = value;
    end
  endfunction

endpackage

// File: rtl/pid_ctrl_gen2_if.sv
// Sample-in / control-out bundle between the inertial front end and the PID core.
interface pid_ctrl_gen2_if #(
  parameter int OUT_W = 12
);
  logic signed [15:0]      ptch;
  logic signed [15:0]      ptch_rt;
  logic                    vld;
  logic                    rider_off;
  logic [4:0]              kp;
  logic signed [OUT_W-1:0] PID_cntrl;
  logic                    cntrl_vld;
  logic                    sat_hi;
  logic                    sat_lo;

  modport master (
    output ptch, ptch_rt, vld, rider_off, kp,
    input  PID_cntrl, cntrl_vld, sat_hi, sat_lo
  );

  modport slave (
    input  ptch, ptch_rt, vld, rider_off, kp,
    output PID_cntrl, cntrl_vld, sat_hi, sat_lo
  );
endinterface

// File: rtl/soft_start_tmr.sv
// Soft-start ramp: counts up while powered, publishes its top byte, flags completion.
module soft_start_tmr
  import pid_pkg::*;
#(
  parameter int TMR_W  = 27,
  parameter int SS_INC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_up_i,
  output logic [7:0] ss_tmr_o,
  output logic       ss_done_o
);

  ss_state_t        state_q, state_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic [TMR_W:0]   cnt_inc_s;
  logic             ss_done_q, ss_done_d;

  // Next-state and counter update; the counter clamps instead of wrapping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_inc_s = {1'b0, cnt_q} + (TMR_W+1)'(SS_INC);
    if (!pwr_up_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = RAMP;
        end
        RAMP: begin
          cnt_d = cnt_inc_s[TMR_W] ? '1 : cnt_inc_s[TMR_W-1:0];
          if (&cnt_d[TMR_W-1 -: 8]) begin
            state_d = RUN;
          end else begin
            state_d = RAMP;
          end
        end
        RUN: begin
          cnt_d   = cnt_q;
          state_d = RUN;
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
    ss_done_d = (state_d == RUN);
  end

  // State, counter and done-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ss_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ss_done_q <= ss_done_d;
    end
  end

  assign ss_tmr_o  = cnt_q[TMR_W-1 -: 8];
  assign ss_done_o = ss_done_q;

endmodule

// File: rtl/pid_ctrl_gen2.sv
// Gen-2 balance PID: saturated error, programmable P, shifted I/D, anti-windup,
// registered saturated output, plus an independent soft-start timer.
module pid_ctrl_gen2
  import pid_pkg::*;
#(
  parameter int ERR_W   = 10,
  parameter int OUT_W   = 12,
  parameter int INT_W   = 18,
  parameter int I_SHIFT = 6,
  parameter int D_SHIFT = 6,
  parameter int TMR_W   = 27,
  parameter int SS_INC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwr_up,
  pid_ctrl_gen2_if.slave   pid_if,
  output logic [7:0]       ss_tmr,
  output logic             ss_done
);

  localparam int P_W   = ERR_W + 6;
  localparam int I_W   = INT_W - I_SHIFT;
  localparam int D_W   = 16 - D_SHIFT + 1;
  localparam int M1_W  = (P_W > I_W) ? P_W : I_W;
  localparam int M_W   = (M1_W > D_W) ? M1_W : D_W;
  localparam int SUM_W = M_W + 2;

  logic signed [ERR_W-1:0] err_s;
  logic                    err_pos_s, err_neg_s;
  logic signed [P_W-1:0]   p_s;
  logic signed [15:0]      rt_shift_s;
  logic signed [D_W-1:0]   d_s;
  logic signed [INT_W:0]   int_sum_s;
  logic                    int_ovf_s, int_block_s;
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic signed [I_W-1:0]   i_s;
  logic signed [SUM_W-1:0] sum_s;
  logic signed [31:0]      sum_sat_s;
  logic                    clip_s;
  logic signed [OUT_W-1:0] pid_q, pid_d;
  logic                    sat_hi_q, sat_hi_d;
  logic                    sat_lo_q, sat_lo_d;
  logic                    vld_q, vld_d;

  // Terms, integrator next value and output candidate for the current sample.
  always_comb begin
    err_s      = ERR_W'(sat_signed(32'(pid_if.ptch), ERR_W));
    err_pos_s  = !err_s[ERR_W-1] && (err_s != '0);
    err_neg_s  = err_s[ERR_W-1];
    p_s        = $signed(P_W'(err_s)) * $signed(P_W'({1'b0, pid_if.kp}));
    rt_shift_s = pid_if.ptch_rt >>> D_SHIFT;
    d_s        = -(D_W'(rt_shift_s));

    // The flags from the previous sample gate integration toward the clipped side.
    int_sum_s   = (INT_W+1)'(integ_q) + (INT_W+1)'(err_s);
    int_ovf_s   = int_sum_s[INT_W] != int_sum_s[INT_W-1];
    int_block_s = (sat_hi_q && err_pos_s) || (sat_lo_q && err_neg_s);

    if (pid_if.rider_off) begin
      integ_d = '0;
    end else if (pid_if.vld && !int_ovf_s && !int_block_s) begin
      integ_d = int_sum_s[INT_W-1:0];
    end else begin
      integ_d = integ_q;
    end

    i_s       = I_W'(integ_d >>> I_SHIFT);
    sum_s     = SUM_W'(p_s) + SUM_W'(i_s) + SUM_W'(d_s);
    sum_sat_s = sat_signed(32'(sum_s), OUT_W);
    clip_s    = sum_sat_s != 32'(sum_s);

    vld_d = pid_if.vld;
    if (pid_if.vld) begin
      pid_d    = OUT_W'(sum_sat_s);
      sat_hi_d = clip_s && !sum_s[SUM_W-1];
      sat_lo_d = clip_s && sum_s[SUM_W-1];
    end else begin
      pid_d    = pid_q;
      sat_hi_d = sat_hi_q;
      sat_lo_d = sat_lo_q;
    end
  end

  // Integrator, output and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_q  <= '0;
      pid_q    <= '0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      integ_q  <= integ_d;
      pid_q    <= pid_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
      vld_q    <= vld_d;
    end
  end

  assign pid_if.PID_cntrl = pid_q;
  assign pid_if.cntrl_vld = vld_q;
  assign pid_if.sat_hi    = sat_hi_q;
  assign pid_if.sat_lo    = sat_lo_q;

  soft_start_tmr #(
    .TMR_W  (TMR_W),
    .SS_INC (SS_INC)
  ) u_soft_start (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwr_up_i  (pwr_up),
    .ss_tmr_o  (ss_tmr),
    .ss_done_o (ss_done)
  );

endmodule

// File: tb/tb_pid_ctrl_gen2.sv
// Directed bench for pid_ctrl_gen2: scoreboarded PID samples plus soft-start and reset checks.
module tb_pid_ctrl_gen2;

  localparam int OUT_W    = 12;
  localparam int TMR_W    = 27;
  localparam int SS_INC   = 16384;
  localparam int RAMP_CYC = 255 * (1 << (TMR_W - 8)) / SS_INC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwr_up = 1'b0;
  logic [7:0] ss_tmr;
  logic       ss_done;

  pid_ctrl_gen2_if #(.OUT_W(OUT_W)) bus ();

  pid_ctrl_gen2 #(.OUT_W(OUT_W), .TMR_W(TMR_W), .SS_INC(SS_INC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwr_up  (pwr_up),
    .pid_if  (bus),
    .ss_tmr  (ss_tmr),
    .ss_done (ss_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pid;
    bit hi;
    bit lo;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pid"}, 32'(bus.PID_cntrl), 32'sd0);
    chk({tag, "_vld"}, 32'(bus.cntrl_vld), 32'sd0);
    chk({tag, "_hi"}, 32'(bus.sat_hi), 32'sd0);
    chk({tag, "_lo"}, 32'(bus.sat_lo), 32'sd0);
    chk({tag, "_tmr"}, 32'(ss_tmr), 32'sd0);
    chk({tag, "_done"}, 32'(ss_done), 32'sd0);
  endtask

  // Pops the oldest expected result and compares it with what the DUT presents now.
  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_cvld"}, 32'(bus.cntrl_vld), 32'sd1);
    n_assert++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_pid"}, 32'(bus.PID_cntrl), e.pid);
      chk({tag, "_hi"}, 32'(bus.sat_hi), 32'(e.hi));
      chk({tag, "_lo"}, 32'(bus.sat_lo), 32'(e.lo));
    end
  endtask

  task automatic sample(input string tag, input logic signed [15:0] p, input logic signed [15:0] r,
                        input logic [4:0] k, input int exp_pid, input bit hi, input bit lo);
    @(negedge clk);
    bus.ptch      = p;
    bus.ptch_rt   = r;
    bus.kp        = k;
    bus.rider_off = 1'b0;
    bus.vld       = 1'b1;
    sb_q.push_back('{exp_pid, hi, lo});
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic idle(input string tag, input int n, input int hold_pid, input bit rider);
    @(negedge clk);
    bus.vld       = 1'b0;
    bus.rider_off = rider;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_cvld"}, 32'(bus.cntrl_vld), 32'sd0);
      chk({tag, "_hold"}, 32'(bus.PID_cntrl), hold_pid);
    end
    @(negedge clk);
    bus.rider_off = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.vld = 1'b0;
    pwr_up  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int      cyc;
    bit      mono_ok;
    bit      done_seen;
    logic [7:0] prev_tmr;

    bus.ptch = 16'sd0; bus.ptch_rt = 16'sd0; bus.vld = 1'b0;
    bus.rider_off = 1'b0; bus.kp = 5'd9;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    sample("basic", 16'sd100, 16'sd0, 5'd9, 901, 1'b0, 1'b0);
    idle("basic_idle", 2, 901, 1'b0);

    // Positive clipping and anti-windup with back-to-back samples.
    do_reset();
    sample("satp", 16'sh7FFF, 16'sd0, 5'd9, 2047, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      sample($sformatf("aw_%0d", i), 16'sd1000, 16'sd0, 5'd9, 2047, 1'b1, 1'b0);
    sample("b2b_neg", -16'sd100, 16'sd0, 5'd9, -894, 1'b0, 1'b0);
    sample("i_only", 16'sd0, 16'sd0, 5'd9, 6, 1'b0, 1'b0);
    idle("rider", 1, 6, 1'b1);
    sample("rider_clr", 16'sd0, 16'sd0, 5'd9, 0, 1'b0, 1'b0);

    do_reset();
    sample("d_pos", 16'sd0, 16'sd640, 5'd9, -10, 1'b0, 1'b0);
    sample("d_min", 16'sd0, 16'sh8000, 5'd9, 512, 1'b0, 1'b0);

    // Negative clipping, anti-windup holds integrator at -512 (I = -8).
    do_reset();
    sample("satn", 16'sh8000, 16'sd0, 5'd31, -2048, 1'b0, 1'b1);
    sample("awn", -16'sd1000, 16'sd0, 5'd31, -2048, 1'b0, 1'b1);
    sample("awn_i", 16'sd0, 16'sd0, 5'd31, -8, 1'b0, 1'b0);

    do_reset();
    sample("lim_hi", 16'sd200, -16'sd2816, 5'd10, 2047, 1'b0, 1'b0);
    do_reset();
    sample("lim_lo", -16'sd200, 16'sd2816, 5'd10, -2048, 1'b0, 1'b0);

    // Integrator growth up to the INT_W overflow hold.
    do_reset();
    for (int k = 1; k <= 256; k++)
      sample($sformatf("iacc_%0d", k), 16'sd511, 16'sd0, 5'd0, (k * 511) / 64, 1'b0, 1'b0);
    sample("iovf_hold", 16'sd511, 16'sd0, 5'd0, 2044, 1'b0, 1'b0);
    sample("iovf_top", 16'sd255, 16'sd0, 5'd0, 2047, 1'b0, 1'b0);
    idle("iovf_idle", 1, 2047, 1'b0);

    // Soft-start ramp.
    do_reset();
    @(negedge clk);
    pwr_up    = 1'b1;
    mono_ok   = 1'b1;
    done_seen = 1'b0;
    prev_tmr  = 8'd0;
    cyc       = 0;
    while (!done_seen && cyc < RAMP_CYC + 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ss_tmr < prev_tmr) mono_ok = 1'b0;
      prev_tmr = ss_tmr;
      if (ss_done === 1'b1) done_seen = 1'b1;
    end
    chk("ss_done_seen", 32'(done_seen), 32'sd1);
    chk("ss_monotonic", 32'(mono_ok), 32'sd1);
    chk("ss_done_cycle", 32'((cyc >= RAMP_CYC) && (cyc <= RAMP_CYC + 1)), 32'sd1);
    chk("ss_tmr_full", 32'(ss_tmr), 32'sd255);
    repeat (20) @(posedge clk);
    #1;
    chk("ss_hold_tmr", 32'(ss_tmr), 32'sd255);
    chk("ss_hold_done", 32'(ss_done), 32'sd1);
    @(negedge clk);
    pwr_up = 1'b0;
    @(posedge clk);
    #1;
    chk("ss_off_tmr", 32'(ss_tmr), 32'sd0);
    chk("ss_off_done", 32'(ss_done), 32'sd0);

    // Asynchronous reset in the middle of a ramp with a live output.
    sample("pre_rst", 16'sd100, 16'sd0, 5'd9, 901, 1'b0, 1'b0);
    @(negedge clk);
    bus.vld = 1'b0;
    pwr_up  = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("ramp_mid", 32'(ss_tmr), 32'((99 * SS_INC) >> (TMR_W - 8)));
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    pwr_up = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset lands between the vld strobe and its output edge.
    @(negedge clk);
    bus.ptch = 16'sd100; bus.ptch_rt = 16'sd0; bus.kp = 5'd9; bus.vld = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("rst_in_sample");
    @(negedge clk);
    bus.vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("post_rst_cvld", 32'(bus.cntrl_vld), 32'sd0);
      chk("post_rst_pid", 32'(bus.PID_cntrl), 32'sd0);
    end

    chk("sb_drained", 32'(sb_q.size()), 32'sd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
